// File: rtl/ucode_pkg.sv
// Shared microcode definitions: control-word field layout, sequencing
// opcodes and sequencer FSM states.
package ucode_pkg;

  localparam int AW = 5;
  localparam int CW = 29;

  localparam int SEQ_HI = 6;
  localparam int SEQ_LO = 5;
  localparam int NA_HI  = 4;
  localparam int NA_LO  = 0;

  typedef enum logic [1:0] {
    SEQ_FETCH    = 2'b00,
    SEQ_BRANCH   = 2'b01,
    SEQ_DISPATCH = 2'b10,
    SEQ_NEXT     = 2'b11
  } seq_e;

  typedef enum logic {
    ST_ISSUE = 1'b0,
    ST_EXEC  = 1'b1
  } state_e;

endpackage

// File: rtl/next_addr_mux.sv
// Next-microaddress selection from the sequencing field; combinational, zero
// latency, no flow control. All arithmetic wraps at AW bits.
module next_addr_mux #(
  parameter int AW         = ucode_pkg::AW,
  parameter int FETCH_ADDR = 1,
  parameter int MAX_ADDR   = 24
) (
  input  ucode_pkg::seq_e  seq,
  input  logic [AW-1:0]    na,
  input  logic             cond,
  input  logic [3:0]       opcode,
  input  logic [AW-1:0]    addr,
  output logic [AW-1:0]    next,
  output logic             out_of_range
);
  import ucode_pkg::*;

  localparam logic [AW-1:0] FETCH_A = AW'(FETCH_ADDR);
  localparam logic [AW-1:0] MAX_A   = AW'(MAX_ADDR);

  always_comb begin
    next = FETCH_A;
    case (seq)
      SEQ_NEXT:     next = na;
      SEQ_BRANCH:   next = cond ? na : addr + AW'(1);
      SEQ_DISPATCH: next = na + AW'(opcode);
      default:      next = FETCH_A;
    endcase
  end

  assign out_of_range = next > MAX_A;

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: two cycles per microinstruction (ISSUE, EXEC), more
// while stall holds it in EXEC; stall freezes addr and suppresses cw_valid.
module micro_sequencer #(
  parameter int AW         = ucode_pkg::AW,
  parameter int CW         = ucode_pkg::CW,
  parameter int RESET_ADDR = 0,
  parameter int FETCH_ADDR = 1,
  parameter int MAX_ADDR   = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] cwrd,
  input  logic [3:0]    opcode,
  input  logic          cond,
  input  logic          stall,
  output logic [AW-1:0] addr,
  output logic          cw_valid,
  output logic          illegal,
  output logic [AW-1:0] upc_inc
);
  import ucode_pkg::*;

  localparam logic [AW-1:0] RESET_A = AW'(RESET_ADDR);
  localparam logic [AW-1:0] FETCH_A = AW'(FETCH_ADDR);
  localparam logic [AW-1:0] MAX_A   = AW'(MAX_ADDR);

  state_e        state_q;
  state_e        state_d;
  logic          commit;
  logic [AW-1:0] next_addr;
  logic          next_oor;
  seq_e          seq;
  logic [AW-1:0] na;

  assign seq = seq_e'(cwrd[SEQ_HI:SEQ_LO]);
  assign na  = cwrd[NA_HI:NA_LO];

  // Upper control-word bits drive the datapath, not the sequencer.
  logic unused_cw_hi;
  assign unused_cw_hi = ^cwrd[CW-1:SEQ_HI+1];

  next_addr_mux #(
    .AW         (AW),
    .FETCH_ADDR (FETCH_ADDR),
    .MAX_ADDR   (MAX_ADDR)
  ) u_next_addr_mux (
    .seq          (seq),
    .na           (na),
    .cond         (cond),
    .opcode       (opcode),
    .addr         (addr),
    .next         (next_addr),
    .out_of_range (next_oor)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ISSUE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ISSUE: state_d = ST_EXEC;
      ST_EXEC:  state_d = stall ? ST_EXEC : ST_ISSUE;
      default:  state_d = ST_ISSUE;
    endcase
  end

  // The valid strobe and the address commit are the same event.
  always_comb begin
    cw_valid = 1'b0;
    commit   = 1'b0;
    case (state_q)
      ST_EXEC: begin
        cw_valid = !stall;
        commit   = !stall;
      end
      default: begin
        cw_valid = 1'b0;
        commit   = 1'b0;
      end
    endcase
  end

  // An out-of-range target is redirected to fetch; the trap flag is sticky.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr    <= RESET_A;
      illegal <= 1'b0;
    end else if (commit) begin
      addr <= next_oor ? FETCH_A : next_addr;
      if (next_oor) begin
        illegal <= 1'b1;
      end
    end
  end

  assign upc_inc = addr + AW'(1);

  a_no_back_to_back_valid: assert property (
    @(posedge clk) disable iff (reset) cw_valid |=> !cw_valid
  );

  a_addr_populated: assert property (
    @(posedge clk) disable iff (reset) addr <= MAX_A
  );

endmodule
